// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite constants and helpers for the read/write masters.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // A buffered response entry is {rresp, rdata}.
  function automatic int unsigned rsp_entry_w(input int unsigned data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; the head entry is read straight from the storage flops,
// so pop_data is registered and holds until popped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A full FIFO accepts a push only when the head leaves on the same edge.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!arst_n)
    !(push && full && !pop));

endmodule

// File: rtl/axi4_lite_rd_mst.sv
// AXI4-Lite read master: pipelined AR issue, in-order response buffering,
// timeout and unexpected-R-beat reporting.
module axi4_lite_rd_mst
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                  clk,
  input  logic                                  arst_n,
  input  logic [ADDR_W-1:0]                     rd_addr,
  input  logic                                  rd_valid,
  output logic                                  rd_ready,
  output logic [DATA_W-1:0]                     rsp_data,
  output logic [1:0]                            rsp_resp,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [ADDR_W-1:0]                     s_axi_araddr,
  output logic                                  s_axi_arvalid,
  input  logic                                  s_axi_arready,
  input  logic [DATA_W-1:0]                     s_axi_rdata,
  input  logic [1:0]                            s_axi_rresp,
  input  logic                                  s_axi_rvalid,
  output logic                                  s_axi_rready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  inflight_cnt,
  output logic                                  timeout_err,
  output logic                                  unexp_rsp_err,
  input  logic                                  err_clr
);

  localparam int CW = $clog2(MAX_OUTSTANDING+1);
  localparam int EW = int'(rsp_entry_w(DATA_W));
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES+1) : 1;

  logic          out_of_rst;
  logic [CW-1:0] used;
  logic          cmd_hs, ar_hs, r_hs, r_push, r_stray, rsp_hs;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_cnt;
  logic [EW-1:0] fifo_dout;
  logic [TW-1:0] tcnt;
  logic          to_idle, to_set;

  // Held low through reset and its first clock so no handshake can be
  // taken while the interconnect is still coming out of reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) out_of_rst <= 1'b0;
    else         out_of_rst <= 1'b1;
  end

  assign s_axi_rready = out_of_rst;
  assign rd_ready     = out_of_rst && (!s_axi_arvalid || s_axi_arready) &&
                        (used < CW'(MAX_OUTSTANDING));

  assign cmd_hs  = rd_valid && rd_ready;
  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  assign r_hs    = s_axi_rvalid && s_axi_rready;
  assign r_push  = r_hs && (inflight_cnt != '0);
  assign r_stray = r_hs && (inflight_cnt == '0);

  assign rsp_valid              = !fifo_empty;
  assign rsp_hs                 = rsp_valid && rsp_ready;
  assign {rsp_resp, rsp_data}   = fifo_dout;

  // `used` reserves FIFO space from command accept to response pop.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) used <= '0;
    else case ({cmd_hs, rsp_hs})
      2'b10:   used <= used + CW'(1);
      2'b01:   used <= used - CW'(1);
      default: used <= used;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s_axi_araddr  <= '0;
      s_axi_arvalid <= 1'b0;
    end else if (cmd_hs) begin
      s_axi_araddr  <= rd_addr;
      s_axi_arvalid <= 1'b1;
    end else if (s_axi_arready) begin
      s_axi_arvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) inflight_cnt <= '0;
    else case ({ar_hs, r_push})
      2'b10:   inflight_cnt <= inflight_cnt + CW'(1);
      2'b01:   inflight_cnt <= inflight_cnt - CW'(1);
      default: inflight_cnt <= inflight_cnt;
    endcase
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_rsp_fifo (
    .clk       (clk),
    .arst_n    (arst_n),
    .push      (r_push),
    .push_data ({s_axi_rresp, s_axi_rdata}),
    .pop       (rsp_hs),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  // Timer runs only while reads are outstanding and no R beat arrives;
  // the flag fires once, on the cycle the count reaches TIMEOUT_CYCLES.
  assign to_idle = r_hs || (inflight_cnt == '0);
  assign to_set  = (TIMEOUT_CYCLES != 0) && !to_idle &&
                   (tcnt == TW'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                            tcnt <= '0;
    else if (to_idle)                       tcnt <= '0;
    else if (tcnt != TW'(TIMEOUT_CYCLES))   tcnt <= tcnt + TW'(1);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      timeout_err   <= 1'b0;
      unexp_rsp_err <= 1'b0;
    end else begin
      if (to_set)       timeout_err   <= 1'b1;
      else if (err_clr) timeout_err   <= 1'b0;
      if (r_stray)      unexp_rsp_err <= 1'b1;
      else if (err_clr) unexp_rsp_err <= 1'b0;
    end
  end

  a_space_reserved: assert property (@(posedge clk) disable iff (!arst_n)
    ({1'b0, fifo_cnt} + {1'b0, inflight_cnt}) <= {1'b0, used});
  a_push_has_room: assert property (@(posedge clk) disable iff (!arst_n)
    !(r_push && fifo_full && !rsp_hs));

endmodule

// File: tb/tb_axi4_lite_rd_mst.sv
// Self-checking bench: table-driven single reads, directed corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_axi4_lite_rd_mst;
  import axi4_lite_pkg::*;

  localparam int AW = 32, DW = 32, MO = 4, TO = 16;
  localparam int CW = $clog2(MO+1);

  logic          clk = 1'b0, arst_n = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_valid = 1'b0, rd_ready;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_resp;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [AW-1:0] s_axi_araddr;
  logic          s_axi_arvalid, s_axi_arready = 1'b0;
  logic [DW-1:0] s_axi_rdata = '0;
  logic [1:0]    s_axi_rresp = '0;
  logic          s_axi_rvalid = 1'b0, s_axi_rready;
  logic [CW-1:0] inflight_cnt;
  logic          timeout_err, unexp_rsp_err, err_clr = 1'b0;

  axi4_lite_rd_mst #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .inflight_cnt(inflight_cnt), .timeout_err(timeout_err), .unexp_rsp_err(unexp_rsp_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic ck(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string tag);
    ck({tag, "_araddr"},   64'(s_axi_araddr), 64'(0));
    ck({tag, "_arvalid"},  64'(s_axi_arvalid), 64'(0));
    ck({tag, "_rready"},   64'(s_axi_rready), 64'(0));
    ck({tag, "_rsp_valid"},64'(rsp_valid), 64'(0));
    ck({tag, "_rd_ready"}, 64'(rd_ready), 64'(0));
    ck({tag, "_inflight"}, 64'(inflight_cnt), 64'(0));
    ck({tag, "_timeout"},  64'(timeout_err), 64'(0));
    ck({tag, "_unexp"},    64'(unexp_rsp_err), 64'(0));
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          rdly;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t vecs[4];

  // Reference model: commands accepted but not yet popped, commands waiting
  // for AR, ARs waiting for R, and the number of buffered responses.
  logic [31:0] exp_q[$], ar_q[$], slv_q[$];
  int fifo_n = 0;

  function automatic logic [31:0] rdat(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction
  function automatic logic [1:0] rrsp(input logic [31:0] a);
    return a[5:4];
  endfunction

  task automatic rnd_cycle(input bit drain);
    cyc();
    rd_valid      = !drain && ($urandom_range(0, 3) != 0);
    rd_addr       = $urandom & 32'hFFFF_FFFC;
    s_axi_arready = drain || ($urandom_range(0, 3) != 0);
    rsp_ready     = drain || ($urandom_range(0, 2) != 0);
    if (slv_q.size() > 0 && (drain || $urandom_range(0, 2) != 0)) begin
      s_axi_rvalid = 1'b1;
      s_axi_rdata  = rdat(slv_q[0]);
      s_axi_rresp  = rrsp(slv_q[0]);
    end else begin
      s_axi_rvalid = 1'b0;
      s_axi_rdata  = $urandom;
      s_axi_rresp  = 2'($urandom);
    end
    @(negedge clk);
    ck("r_rready",    64'(s_axi_rready), 64'(1));
    ck("r_inflight",  64'(inflight_cnt), 64'(slv_q.size()));
    ck("r_rsp_valid", 64'(rsp_valid), 64'(fifo_n > 0));
    ck("r_arvalid",   64'(s_axi_arvalid), 64'(ar_q.size() > 0));
    if (ar_q.size() > 0) ck("r_araddr", 64'(s_axi_araddr), 64'(ar_q[0]));
    if (exp_q.size() >= MO)     ck("r_no_room", 64'(rd_ready), 64'(0));
    else if (ar_q.size() == 0)  ck("r_room",    64'(rd_ready), 64'(1));
    if (rsp_valid && exp_q.size() > 0) begin
      ck("r_rsp_data", 64'(rsp_data), 64'(rdat(exp_q[0])));
      ck("r_rsp_resp", 64'(rsp_resp), 64'(rrsp(exp_q[0])));
    end
    if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
      void'(exp_q.pop_front()); fifo_n--;
    end
    if (s_axi_rvalid && s_axi_rready && slv_q.size() > 0) begin
      void'(slv_q.pop_front()); fifo_n++;
    end
    if (s_axi_arvalid && s_axi_arready && ar_q.size() > 0) slv_q.push_back(ar_q.pop_front());
    if (rd_valid && rd_ready) begin
      exp_q.push_back(rd_addr);
      ar_q.push_back(rd_addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    vecs[0] = '{32'h0000_1000, 32'hDEAD_BEEF, RESP_OKAY,   2, 32'hDEAD_BEEF, RESP_OKAY};
    vecs[1] = '{32'h0000_1004, 32'h1234_5678, RESP_SLVERR, 0, 32'h1234_5678, RESP_SLVERR};
    vecs[2] = '{32'h0000_1008, 32'h0F0F_0F0F, RESP_OKAY,   1, 32'h0F0F_0F0F, RESP_OKAY};
    vecs[3] = '{32'hFFFF_FFFC, 32'hA5A5_A5A5, RESP_DECERR, 3, 32'hA5A5_A5A5, RESP_DECERR};

    // Reset state
    @(negedge clk);
    chk_reset("rst");
    cyc(); arst_n = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    ck("post_rst_rready", 64'(s_axi_rready), 64'(1));
    ck("post_rst_rd_ready", 64'(rd_ready), 64'(1));

    // Table-driven single reads (row 1 carries SLVERR between two OKAYs)
    s_axi_arready = 1'b1;
    foreach (vecs[i]) begin
      cyc(); rd_valid = 1'b1; rd_addr = vecs[i].addr;
      @(negedge clk); ck("t_rd_ready", 64'(rd_ready), 64'(1));
      cyc(); rd_valid = 1'b0;
      @(negedge clk);
      ck("t_araddr", 64'(s_axi_araddr), 64'(vecs[i].addr));
      ck("t_arvalid", 64'(s_axi_arvalid), 64'(1));
      ck("t_infl0", 64'(inflight_cnt), 64'(0));
      for (int k = 0; k < vecs[i].rdly; k++) begin
        cyc(); @(negedge clk); ck("t_infl_wait", 64'(inflight_cnt), 64'(1));
      end
      cyc(); s_axi_rvalid = 1'b1; s_axi_rdata = vecs[i].rdata; s_axi_rresp = vecs[i].rresp;
      @(negedge clk);
      ck("t_rsp_early", 64'(rsp_valid), 64'(0));
      ck("t_infl1", 64'(inflight_cnt), 64'(1));
      cyc(); s_axi_rvalid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      ck("t_rsp_valid", 64'(rsp_valid), 64'(1));
      ck("t_rsp_data", 64'(rsp_data), 64'(vecs[i].exp_data));
      ck("t_rsp_resp", 64'(rsp_resp), 64'(vecs[i].exp_resp));
      ck("t_infl_back", 64'(inflight_cnt), 64'(0));
      cyc(); rsp_ready = 1'b0;
      @(negedge clk); ck("t_rsp_gone", 64'(rsp_valid), 64'(0));
    end
    ck("t_no_timeout", 64'(timeout_err), 64'(0));
    ck("t_no_unexp", 64'(unexp_rsp_err), 64'(0));

    // Pipelined: four back-to-back commands, fifth blocked until a pop
    for (int i = 0; i < 4; i++) begin
      cyc(); rd_valid = 1'b1; rd_addr = 32'(i * 4);
      @(negedge clk); ck("p_rd_ready", 64'(rd_ready), 64'(1));
      if (i > 0) begin
        ck("p_araddr", 64'(s_axi_araddr), 64'((i - 1) * 4));
        ck("p_arvalid", 64'(s_axi_arvalid), 64'(1));
      end
    end
    cyc(); rd_addr = 32'h10;
    @(negedge clk);
    ck("p_blocked", 64'(rd_ready), 64'(0));
    ck("p_araddr_last", 64'(s_axi_araddr), 64'(32'hC));
    for (int i = 0; i < 4; i++) begin
      cyc(); s_axi_rvalid = 1'b1; s_axi_rdata = 32'h100 + 32'(i); s_axi_rresp = RESP_OKAY;
      @(negedge clk);
      ck("p_block_r", 64'(rd_ready), 64'(0));
      ck("p_infl", 64'(inflight_cnt), 64'(4 - i));
    end
    cyc(); s_axi_rvalid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    ck("p_full_block", 64'(rd_ready), 64'(0));
    ck("p_data0", 64'(rsp_data), 64'(32'h100));
    cyc();
    @(negedge clk);
    ck("p_unblock", 64'(rd_ready), 64'(1));
    ck("p_data1", 64'(rsp_data), 64'(32'h101));
    cyc(); rd_valid = 1'b0;
    @(negedge clk);
    ck("p_araddr5", 64'(s_axi_araddr), 64'(32'h10));
    ck("p_data2", 64'(rsp_data), 64'(32'h102));
    cyc(); s_axi_rvalid = 1'b1; s_axi_rdata = 32'h104;
    @(negedge clk); ck("p_data3", 64'(rsp_data), 64'(32'h103));
    cyc(); s_axi_rvalid = 1'b0;
    @(negedge clk); ck("p_data4", 64'(rsp_data), 64'(32'h104));
    cyc(); rsp_ready = 1'b0;
    @(negedge clk);
    ck("p_empty", 64'(rsp_valid), 64'(0));
    ck("p_infl_end", 64'(inflight_cnt), 64'(0));

    // AR backpressure: arready low for five cycles
    s_axi_arready = 1'b0;
    cyc(); rd_valid = 1'b1; rd_addr = 32'h3000;
    @(negedge clk); ck("b_rd_ready", 64'(rd_ready), 64'(1));
    cyc(); rd_addr = 32'h3004;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ck("b_arvalid", 64'(s_axi_arvalid), 64'(1));
      ck("b_araddr", 64'(s_axi_araddr), 64'(32'h3000));
      ck("b_rd_ready_lo", 64'(rd_ready), 64'(0));
      cyc();
    end
    s_axi_arready = 1'b1;
    @(negedge clk);
    ck("b_rd_ready_hi", 64'(rd_ready), 64'(1));
    ck("b_araddr_hold", 64'(s_axi_araddr), 64'(32'h3000));
    cyc(); rd_valid = 1'b0;
    @(negedge clk);
    ck("b_araddr2", 64'(s_axi_araddr), 64'(32'h3004));
    ck("b_infl1", 64'(inflight_cnt), 64'(1));
    cyc(); s_axi_rvalid = 1'b1; s_axi_rdata = 32'h3000_AAAA; s_axi_rresp = RESP_OKAY;
    @(negedge clk);
    ck("b_arvalid_lo", 64'(s_axi_arvalid), 64'(0));
    ck("b_infl2", 64'(inflight_cnt), 64'(2));
    cyc(); s_axi_rdata = 32'h3004_BBBB; s_axi_rresp = RESP_DECERR;
    @(negedge clk);
    cyc(); s_axi_rvalid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    ck("b_data0", 64'(rsp_data), 64'(32'h3000_AAAA));
    ck("b_resp0", 64'(rsp_resp), 64'(RESP_OKAY));
    cyc();
    @(negedge clk);
    ck("b_data1", 64'(rsp_data), 64'(32'h3004_BBBB));
    ck("b_resp1", 64'(rsp_resp), 64'(RESP_DECERR));
    cyc(); rsp_ready = 1'b0;
    @(negedge clk); ck("b_empty", 64'(rsp_valid), 64'(0));

    // Timeout: flag rises 16 cycles after the AR handshake
    cyc(); rd_valid = 1'b1; rd_addr = 32'h4000;
    cyc(); rd_valid = 1'b0;
    @(negedge clk); ck("to_arvalid", 64'(s_axi_arvalid), 64'(1));
    for (int j = 0; j < TO; j++) begin
      cyc(); @(negedge clk); ck("to_quiet", 64'(timeout_err), 64'(0));
    end
    cyc(); @(negedge clk); ck("to_set", 64'(timeout_err), 64'(1));
    cyc(); s_axi_rvalid = 1'b1; s_axi_rdata = 32'h0BAD_F00D; s_axi_rresp = RESP_OKAY;
    @(negedge clk); ck("to_sticky", 64'(timeout_err), 64'(1));
    cyc(); s_axi_rvalid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    ck("to_late_valid", 64'(rsp_valid), 64'(1));
    ck("to_late_data", 64'(rsp_data), 64'(32'h0BAD_F00D));
    cyc(); rsp_ready = 1'b0; err_clr = 1'b1;
    @(negedge clk); ck("to_before_clr", 64'(timeout_err), 64'(1));
    cyc(); err_clr = 1'b0;
    @(negedge clk);
    ck("to_cleared", 64'(timeout_err), 64'(0));
    ck("to_infl", 64'(inflight_cnt), 64'(0));

    // Stray R beat while idle, with err_clr on the same cycle (set wins)
    cyc(); s_axi_rvalid = 1'b1; s_axi_rdata = 32'h1111_1111; err_clr = 1'b1;
    @(negedge clk);
    cyc(); s_axi_rvalid = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    ck("u_flag", 64'(unexp_rsp_err), 64'(1));
    ck("u_no_rsp", 64'(rsp_valid), 64'(0));
    ck("u_infl", 64'(inflight_cnt), 64'(0));
    cyc();
    @(negedge clk); ck("u_no_rsp2", 64'(rsp_valid), 64'(0));

    // Reset mid-burst with two reads in flight and a third on AR
    s_axi_arready = 1'b1;
    cyc(); rd_valid = 1'b1; rd_addr = 32'h5000;
    cyc(); rd_addr = 32'h5004;
    cyc(); rd_addr = 32'h5008;
    cyc(); rd_valid = 1'b0; s_axi_arready = 1'b0;
    @(negedge clk);
    ck("m_infl", 64'(inflight_cnt), 64'(2));
    ck("m_arvalid", 64'(s_axi_arvalid), 64'(1));
    #1 arst_n = 1'b0;
    #1 chk_reset("mid_rst");
    cyc(); cyc(); arst_n = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    ck("m_rready", 64'(s_axi_rready), 64'(1));
    ck("m_rd_ready", 64'(rd_ready), 64'(1));

    // Randomized traffic against the reference model, then drain
    for (int n = 0; n < 1500; n++) rnd_cycle(1'b0);
    guard = 0;
    while (exp_q.size() > 0 && guard < 300) begin
      rnd_cycle(1'b1);
      guard++;
    end
    ck("r_drained", 64'(exp_q.size()), 64'(0));
    ck("r_no_timeout", 64'(timeout_err), 64'(0));
    ck("r_no_unexp", 64'(unexp_rsp_err), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_lite_rd_mst.md
Name: axi4_lite_rd_mst

Overview:
Parametrised AXI4-Lite read master that replaces the single-transaction read engine. It accepts read commands on a valid/ready user port and issues them on AR with up to MAX_OUTSTANDING reads in flight. Data and responses return in order through an internal response FIFO to a user response port. It sits between register-access clients (CSR sequencers, debug bridges) and an AXI4-Lite interconnect slave port, and adds timeout and protocol-error reporting.

Parameters:
ADDR_W, 32, address width of rd_addr and s_axi_araddr
DATA_W, 32, read data width (32 or 64 per AXI4-Lite)
MAX_OUTSTANDING, 4, maximum reserved transactions (issued + buffered), power of 2, 1..16
TIMEOUT_CYCLES, 1024, cycles without an R beat while reads are in flight before timeout_err is set; 0 disables the timeout

Ports:
clk  in  1  system clock, all logic on rising edge
arst_n  in  1  asynchronous active-low reset; asserts asynchronously, is released synchronously to clk by the upstream reset synchroniser
rd_addr  in  ADDR_W  read command address
rd_valid  in  1  command valid
rd_ready  out  1  command accepted when rd_valid && rd_ready
rsp_data  out  DATA_W  read data to user
rsp_resp  out  2  RRESP passed through unchanged
rsp_valid  out  1  response valid
rsp_ready  in  1  user accepts response
s_axi_araddr  out  ADDR_W  AR address
s_axi_arvalid  out  1  AR valid
s_axi_arready  in  1  AR ready
s_axi_rdata  in  DATA_W  R data
s_axi_rresp  in  2  R response
s_axi_rvalid  in  1  R valid
s_axi_rready  out  1  R ready
inflight_cnt  out  $clog2(MAX_OUTSTANDING+1)  AR handshakes minus R handshakes
timeout_err  out  1  sticky timeout flag
unexp_rsp_err  out  1  sticky flag: R beat received with inflight_cnt==0
err_clr  in  1  single-cycle clear of both sticky flags

Behaviour:
- Reset values: s_axi_arvalid=0, s_axi_araddr=0, s_axi_rready=0, rsp_valid=0, rd_ready=0, inflight_cnt=0, used=0, timeout counter=0, both error flags=0, FIFO empty.
- Reserved count: internal `used` increments on a command handshake and decrements on a rsp handshake. Simultaneous increment and decrement leaves it unchanged. It never exceeds MAX_OUTSTANDING.
- rd_ready = (!s_axi_arvalid || s_axi_arready) && (used < MAX_OUTSTANDING). This is the only combinational path from s_axi_arready.
- AR channel: on a command handshake, register s_axi_araddr<=rd_addr and s_axi_arvalid<=1 on the next edge. arvalid and araddr hold stable until arready. Back-to-back commands give one AR per cycle while arready=1.
- inflight_cnt: +1 on AR handshake, -1 on R handshake, unchanged when both occur in the same cycle.
- s_axi_rready = 1 in every cycle after reset. FIFO space is guaranteed by `used`, so R beats are never stalled.
- R handshake with inflight_cnt>0: push {rresp, rdata} into the FIFO. rsp_valid rises on the edge after the push, giving 1-cycle latency from R handshake to rsp_valid.
- R handshake with inflight_cnt==0: drop the beat, set unexp_rsp_err, leave counters unchanged.
- Responses leave in issue order. rsp_data and rsp_resp hold stable while rsp_valid && !rsp_ready.
- Full-throughput condition: arready=1, rvalid tracking, rsp_ready=1 gives 1 transaction per cycle.
- FIFO full plus simultaneous pop and push is legal and leaves the count unchanged. Push when full is impossible by construction and is covered by an assertion.
- Timeout counter: clears on any R handshake or when inflight_cnt==0, otherwise increments and saturates. Reaching TIMEOUT_CYCLES sets timeout_err. The block keeps waiting and does not abort or synthesise a response.
- err_clr clears both flags. If err_clr coincides with a set event, the set wins.
- Reset mid-operation: all state returns to reset values immediately. Transactions in flight are lost and the interconnect must be reset in the same domain.
- SLVERR/DECERR are not errors inside this block. They are only reported on rsp_resp.

Decomposition:
- Shared package axi4_lite_pkg holds the RESP_OKAY/EXOKAY/SLVERR/DECERR 2-bit constants and the response-entry width function DATA_W+2.
- One sub-module, sync_fifo: parametrised WIDTH/DEPTH, registered output, push/pop/full/empty/count. It is reused later by the write master.

Test Plan:
- Single read: rd_addr=0x1000, arready same cycle, rvalid 2 cycles later with rdata=0xDEADBEEF, rresp=0 -> araddr=0x1000 one cycle after accept; rsp_valid the cycle after the R beat with rsp_data=0xDEADBEEF; inflight_cnt goes 0-1-0.
- Pipelined: 4 commands 0x0, 0x4, 0x8, 0xC back-to-back, arready=1, rsp_ready=0 -> 4 AR beats in consecutive cycles; rd_ready=0 for the 5th command until one response is popped; responses pop in order.
- Backpressure: arready low for 5 cycles -> arvalid and araddr stable throughout; rd_ready=0 during that time; the handshake completes when arready rises.
- Error passthrough: rresp=2'b10 on the 2nd of 3 reads -> rsp_resp=2 for that entry only; no sticky flag set.
- Timeout: TIMEOUT_CYCLES=16, one read with no R beat -> timeout_err=1 exactly 16 cycles after the AR handshake; a late R beat is still delivered; err_clr -> 0.
- Stray R beat while idle -> unexp_rsp_err=1, no rsp_valid; then assert arst_n low mid-burst with 2 reads in flight -> all outputs return to reset values asynchronously.
